// File: rtl/ide_device_pkg.sv
// rtl/ide_device_pkg.sv - shared FSM states, task-file offsets, status bits and opcodes for ide_device
package ide_device_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_FETCH,
        RD_XFER,
        WR_XFER,
        WR_STORE
    } state_t;

    localparam logic [1:0] CS_CMD  = 2'b10;
    localparam logic [1:0] CS_CTRL = 2'b01;

    localparam logic [2:0] REG_DATA    = 3'd0;
    localparam logic [2:0] REG_ERROR   = 3'd1;
    localparam logic [2:0] REG_COUNT   = 3'd2;
    localparam logic [2:0] REG_LBA_LO  = 3'd3;
    localparam logic [2:0] REG_LBA_MID = 3'd4;
    localparam logic [2:0] REG_LBA_HI  = 3'd5;
    localparam logic [2:0] REG_DEVICE  = 3'd6;
    localparam logic [2:0] REG_STATUS  = 3'd7;
    // control block: alt status on read, device control on write
    localparam logic [2:0] REG_DEVCTL  = 3'd6;

    localparam int ST_BSY  = 7;
    localparam int ST_DRDY = 6;
    localparam int ST_DSC  = 4;
    localparam int ST_DRQ  = 3;
    localparam int ST_ERR  = 0;

    localparam int ERR_ABRT    = 2;
    localparam int DEVCTL_SRST = 2;

    localparam logic [7:0] CMD_READ_SECTORS  = 8'h20;
    localparam logic [7:0] CMD_WRITE_SECTORS = 8'h30;

    function automatic logic [7:0] pack_status(input logic bsy, input logic drq, input logic err);
        logic [7:0] s;
        s          = 8'h00;
        s[ST_BSY]  = bsy;
        s[ST_DRDY] = ~bsy;
        s[ST_DSC]  = ~bsy;
        s[ST_DRQ]  = drq;
        s[ST_ERR]  = err;
        return s;
    endfunction

endpackage

// File: rtl/ide_device_secbuf.sv
// rtl/ide_device_secbuf.sv - 256x16 sector buffer, one write port and one registered read port
module ide_device_secbuf (
    input  logic        i_clk,
    input  logic        i_we,
    input  logic [7:0]  i_waddr,
    input  logic [15:0] i_wdata,
    input  logic [7:0]  i_raddr,
    output logic [15:0] o_rdata
);

    logic [15:0] r_mem [0:255];

    always_ff @(posedge i_clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
        o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/ide_device.sv
// rtl/ide_device.sv - IDE/ATA PIO device: task file, sector read/write FSM, memory port; IDE_DEVICE_SYNC_EN adds strobe synchronizers
module ide_device
    import ide_device_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ide_data_in,
    output logic [15:0] ide_data_out,
    input  logic        ide_dior,
    input  logic        ide_diow,
    input  logic [1:0]  ide_cs,
    input  logic [2:0]  ide_da,
    output logic        mem_req,
    output logic        mem_we,
    output logic [35:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack
);

    logic        w_dior, w_diow;
    logic [1:0]  w_cs;
    logic [2:0]  w_da;

`ifdef IDE_DEVICE_SYNC_EN
    logic        r_dior_s1, r_dior_s2, r_diow_s1, r_diow_s2;
    logic [1:0]  r_cs_s1, r_cs_s2;
    logic [2:0]  r_da_s1, r_da_s2;

    // cs/da ride the same two stages so they stay aligned with the strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dior_s1 <= 1'b1;  r_dior_s2 <= 1'b1;
            r_diow_s1 <= 1'b1;  r_diow_s2 <= 1'b1;
            r_cs_s1   <= 2'b11; r_cs_s2   <= 2'b11;
            r_da_s1   <= 3'd0;  r_da_s2   <= 3'd0;
        end else begin
            r_dior_s1 <= ide_dior; r_dior_s2 <= r_dior_s1;
            r_diow_s1 <= ide_diow; r_diow_s2 <= r_diow_s1;
            r_cs_s1   <= ide_cs;   r_cs_s2   <= r_cs_s1;
            r_da_s1   <= ide_da;   r_da_s2   <= r_da_s1;
        end
    end

    assign w_dior = r_dior_s2;
    assign w_diow = r_diow_s2;
    assign w_cs   = r_cs_s2;
    assign w_da   = r_da_s2;
`else
    assign w_dior = ide_dior;
    assign w_diow = ide_diow;
    assign w_cs   = ide_cs;
    assign w_da   = ide_da;
`endif

    logic        r_dior_d, r_diow_d;
    state_t      r_state;
    logic        r_bsy, r_drq, r_err;
    logic [7:0]  r_error, r_count, r_ptr, r_word;
    logic [27:0] r_lba;
    logic [3:0]  r_dev_hi;
    logic        r_mem_req, r_mem_we;
    logic [15:0] r_data_out;

    logic        w_dior_rise, w_diow_rise, w_cmd_sel, w_ctrl_sel;
    logic        w_srst, w_reg_wr, w_data_wr, w_data_rd_rise, w_fetch_ack;
    logic        w_buf_we;
    logic [7:0]  w_buf_waddr, w_buf_raddr, w_status;
    logic [15:0] w_buf_wdata, w_buf_rdata, w_rd_value;

    assign w_dior_rise    = w_dior & ~r_dior_d;
    assign w_diow_rise    = w_diow & ~r_diow_d;
    assign w_cmd_sel      = (w_cs == CS_CMD);
    assign w_ctrl_sel     = (w_cs == CS_CTRL);
    assign w_srst         = w_diow_rise && w_ctrl_sel && (w_da == REG_DEVCTL) && ide_data_in[DEVCTL_SRST];
    assign w_reg_wr       = w_diow_rise && w_cmd_sel && !r_bsy;
    assign w_data_wr      = w_reg_wr && (w_da == REG_DATA) && r_drq && (r_state == WR_XFER);
    assign w_data_rd_rise = w_dior_rise && w_cmd_sel && (w_da == REG_DATA) && r_drq && (r_state == RD_XFER);
    assign w_fetch_ack    = (r_state == RD_FETCH) && r_mem_req && mem_ack;
    assign w_status       = pack_status(r_bsy, r_drq, r_err);

    assign w_buf_we    = w_fetch_ack | (w_data_wr & ~w_srst);
    assign w_buf_waddr = w_fetch_ack ? r_word : r_ptr;
    assign w_buf_wdata = w_fetch_ack ? mem_rdata : ide_data_in;
    assign w_buf_raddr = (r_state == WR_STORE) ? r_word : r_ptr;

    ide_device_secbuf u_secbuf (
        .i_clk   (clk),
        .i_we    (w_buf_we),
        .i_waddr (w_buf_waddr),
        .i_wdata (w_buf_wdata),
        .i_raddr (w_buf_raddr),
        .o_rdata (w_buf_rdata)
    );

    always_comb begin
        w_rd_value = 16'h0000;
        if (w_cmd_sel) begin
            case (w_da)
                REG_DATA:    w_rd_value = r_drq ? w_buf_rdata : 16'h0000;
                REG_ERROR:   w_rd_value = {8'h00, r_error};
                REG_COUNT:   w_rd_value = {8'h00, r_count};
                REG_LBA_LO:  w_rd_value = {8'h00, r_lba[7:0]};
                REG_LBA_MID: w_rd_value = {8'h00, r_lba[15:8]};
                REG_LBA_HI:  w_rd_value = {8'h00, r_lba[23:16]};
                REG_DEVICE:  w_rd_value = {8'h00, r_dev_hi, r_lba[27:24]};
                default:     w_rd_value = {8'h00, w_status};
            endcase
        end else if (w_ctrl_sel && w_da == REG_DEVCTL) begin
            w_rd_value = {8'h00, w_status};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dior_d   <= 1'b1;
            r_diow_d   <= 1'b1;
            r_state    <= IDLE;
            r_bsy      <= 1'b0;
            r_drq      <= 1'b0;
            r_err      <= 1'b0;
            r_error    <= 8'h00;
            r_count    <= 8'h00;
            r_lba      <= 28'h0;
            r_dev_hi   <= 4'h0;
            r_ptr      <= 8'h00;
            r_word     <= 8'h00;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_data_out <= 16'h0000;
        end else begin
            r_dior_d <= w_dior;
            r_diow_d <= w_diow;
            if (!w_dior)
                r_data_out <= w_rd_value;

            if (w_srst) begin
                r_state   <= IDLE;
                r_bsy     <= 1'b0;
                r_drq     <= 1'b0;
                r_err     <= 1'b0;
                r_error   <= 8'h00;
                r_ptr     <= 8'h00;
                r_word    <= 8'h00;
                r_mem_req <= 1'b0;
                r_mem_we  <= 1'b0;
            end else begin
                if (w_reg_wr) begin
                    case (w_da)
                        REG_COUNT:   r_count      <= ide_data_in[7:0];
                        REG_LBA_LO:  r_lba[7:0]   <= ide_data_in[7:0];
                        REG_LBA_MID: r_lba[15:8]  <= ide_data_in[7:0];
                        REG_LBA_HI:  r_lba[23:16] <= ide_data_in[7:0];
                        REG_DEVICE: begin
                            r_dev_hi     <= ide_data_in[7:4];
                            r_lba[27:24] <= ide_data_in[3:0];
                        end
                        default: ;
                    endcase
                end

                case (r_state)
                    IDLE: begin
                        if (w_reg_wr && w_da == REG_STATUS) begin
                            if (ide_data_in[7:0] == CMD_READ_SECTORS) begin
                                r_bsy     <= 1'b1;
                                r_err     <= 1'b0;
                                r_error   <= 8'h00;
                                r_word    <= 8'h00;
                                r_mem_req <= 1'b1;
                                r_mem_we  <= 1'b0;
                                r_state   <= RD_FETCH;
                            end else if (ide_data_in[7:0] == CMD_WRITE_SECTORS) begin
                                r_err   <= 1'b0;
                                r_error <= 8'h00;
                                r_drq   <= 1'b1;
                                r_ptr   <= 8'h00;
                                r_state <= WR_XFER;
                            end else begin
                                r_err             <= 1'b1;
                                r_error[ERR_ABRT] <= 1'b1;
                            end
                        end
                    end
                    RD_FETCH: begin
                        if (w_fetch_ack) begin
                            r_word <= r_word + 8'd1;
                            if (r_word == 8'hFF) begin
                                r_mem_req <= 1'b0;
                                r_bsy     <= 1'b0;
                                r_drq     <= 1'b1;
                                r_ptr     <= 8'h00;
                                r_state   <= RD_XFER;
                            end
                        end
                    end
                    RD_XFER: begin
                        if (w_data_rd_rise) begin
                            r_ptr <= r_ptr + 8'd1;
                            if (r_ptr == 8'hFF) begin
                                r_count <= r_count - 8'd1;
                                r_lba   <= r_lba + 28'd1;
                                r_drq   <= 1'b0;
                                // count 0 means 256 sectors, so only 1 ends the command
                                if (r_count != 8'd1) begin
                                    r_bsy     <= 1'b1;
                                    r_word    <= 8'h00;
                                    r_mem_req <= 1'b1;
                                    r_mem_we  <= 1'b0;
                                    r_state   <= RD_FETCH;
                                end else begin
                                    r_state <= IDLE;
                                end
                            end
                        end
                    end
                    WR_XFER: begin
                        if (w_data_wr) begin
                            r_ptr <= r_ptr + 8'd1;
                            if (r_ptr == 8'hFF) begin
                                r_drq     <= 1'b0;
                                r_bsy     <= 1'b1;
                                r_word    <= 8'h00;
                                r_mem_req <= 1'b0;
                                r_mem_we  <= 1'b1;
                                r_state   <= WR_STORE;
                            end
                        end
                    end
                    WR_STORE: begin
                        // req drops after every ack so the registered buffer read settles
                        if (!r_mem_req) begin
                            r_mem_req <= 1'b1;
                        end else if (mem_ack) begin
                            r_mem_req <= 1'b0;
                            r_word    <= r_word + 8'd1;
                            if (r_word == 8'hFF) begin
                                r_count  <= r_count - 8'd1;
                                r_lba    <= r_lba + 28'd1;
                                r_mem_we <= 1'b0;
                                r_bsy    <= 1'b0;
                                if (r_count != 8'd1) begin
                                    r_drq   <= 1'b1;
                                    r_ptr   <= 8'h00;
                                    r_state <= WR_XFER;
                                end else begin
                                    r_state <= IDLE;
                                end
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign ide_data_out = r_data_out;
    assign mem_req      = r_mem_req;
    assign mem_we       = r_mem_we;
    assign mem_addr     = {r_lba, r_word};
    assign mem_wdata    = w_buf_rdata;

endmodule

// File: tb/tb_ide_device.sv
// tb/tb_ide_device.sv - directed self-checking bench for ide_device
module tb_ide_device;

`ifdef IDE_DEVICE_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif
    localparam logic [1:0] CMDB = 2'b10;
    localparam logic [1:0] CTLB = 2'b01;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] ide_data_in, ide_data_out;
    logic        ide_dior, ide_diow;
    logic [1:0]  ide_cs;
    logic [2:0]  ide_da;
    logic        mem_req, mem_we;
    logic [35:0] mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic        mem_ack;

    int n_checks = 0;
    int n_pass   = 0;
    int req_cycles = 0;
    logic [35:0] log_addr[$];
    logic        log_we[$];
    logic [15:0] log_wdata[$];

    always #5 clk = ~clk;

    ide_device dut (
        .clk(clk), .reset(reset),
        .ide_data_in(ide_data_in), .ide_data_out(ide_data_out),
        .ide_dior(ide_dior), .ide_diow(ide_diow),
        .ide_cs(ide_cs), .ide_da(ide_da),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // memory model: word k of any sector reads as k, one-cycle ack pulses
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 16'h0000;
        forever begin
            @(posedge clk); #1;
            if (mem_req) req_cycles++;
            if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (mem_req && !reset) begin
                mem_ack   = 1'b1;
                mem_rdata = {8'h00, mem_addr[7:0]};
                log_addr.push_back(mem_addr);
                log_we.push_back(mem_we);
                log_wdata.push_back(mem_wdata);
            end
        end
    end

    task automatic host_wr(input logic [1:0] cs, input logic [2:0] da, input logic [15:0] d);
        @(posedge clk); #1;
        ide_cs = cs; ide_da = da; ide_data_in = d;
        @(posedge clk); #1 ide_diow = 1'b0;
        repeat (3) @(posedge clk);
        #1 ide_diow = 1'b1;
        repeat (3) @(posedge clk);
        #1 ide_cs = 2'b11;
    endtask

    task automatic host_rd(input logic [1:0] cs, input logic [2:0] da, output logic [15:0] v);
        @(posedge clk); #1;
        ide_cs = cs; ide_da = da;
        @(posedge clk); #1 ide_dior = 1'b0;
        repeat (3) @(posedge clk);
        #1 ide_dior = 1'b1;
        repeat (3) @(posedge clk);
        #1 v = ide_data_out;
        ide_cs = 2'b11;
    endtask

    task automatic wait_status(input logic [7:0] exp, input string tag);
        logic [15:0] v;
        v = 16'hFFFF;
        for (int i = 0; i < 300; i++) begin
            host_rd(CMDB, 3'd7, v);
            if (v == {8'h00, exp}) break;
        end
        check(tag, v, {8'h00, exp});
    endtask

    task automatic read_sector(input string tag);
        logic [15:0] v;
        int errs;
        errs = 0;
        for (int k = 0; k < 256; k++) begin
            host_rd(CMDB, 3'd0, v);
            if (v !== 16'(k)) errs++;
        end
        check(tag, errs, 0);
    endtask

    initial begin
        logic [15:0] v;
        int errs, snap;
        logic [35:0] e;

        reset = 1'b1; ide_dior = 1'b1; ide_diow = 1'b1;
        ide_cs = 2'b11; ide_da = 3'd0; ide_data_in = 16'h0000;
        repeat (4) @(posedge clk);
        #1;
        check("reset data_out", ide_data_out, 16'h0000);
        check("reset mem_req", mem_req, 1'b0);
        check("reset mem_we", mem_we, 1'b0);
        reset = 1'b0;
        host_rd(CMDB, 3'd7, v); check("status after reset", v, 16'h0050);
        host_rd(CTLB, 3'd6, v); check("alt status after reset", v, 16'h0050);
        host_rd(CMDB, 3'd2, v); check("count after reset", v, 16'h0000);

        // single-sector read at LBA 0x10, first word read streams word by word
        host_wr(CMDB, 3'd2, 16'h0001);
        host_wr(CMDB, 3'd3, 16'h0010);
        host_wr(CMDB, 3'd4, 16'h0000);
        host_wr(CMDB, 3'd5, 16'h0000);
        host_wr(CMDB, 3'd6, 16'h00E0);
        host_rd(CMDB, 3'd3, v); check("lba lo readback", v, 16'h0010);
        host_rd(CMDB, 3'd6, v); check("device readback", v, 16'h00E0);
        log_addr.delete(); log_we.delete(); log_wdata.delete();
        host_wr(CMDB, 3'd7, 16'h0020);
        wait_status(8'h58, "read1 drq status");
        for (int k = 0; k < 256; k++) begin
            host_rd(CMDB, 3'd0, v);
            check($sformatf("read1 word %0d", k), v, 16'(k));
        end
        host_rd(CMDB, 3'd7, v); check("read1 final status", v, 16'h0050);
        check("read1 mem beats", log_addr.size(), 256);
        errs = 0;
        for (int i = 0; i < log_addr.size(); i++)
            if (log_addr[i] !== (36'h000001000 + 36'(i)) || log_we[i] !== 1'b0) errs++;
        check("read1 mem addr seq", errs, 0);
        check("read1 first addr", log_addr.size() > 0 ? log_addr[0] : 36'hX, 36'h000001000);
        check("read1 last addr", log_addr.size() > 255 ? log_addr[255] : 36'hX, 36'h0000010FF);
        host_rd(CMDB, 3'd3, v); check("read1 lba advanced", v, 16'h0011);
        host_rd(CMDB, 3'd2, v); check("read1 count zero", v, 16'h0000);
        host_rd(CMDB, 3'd0, v); check("data read drq0", v, 16'h0000);

        // unknown opcode aborts without touching memory
        snap = req_cycles;
        host_wr(CMDB, 3'd7, 16'h0091);
        host_rd(CMDB, 3'd7, v); check("abort status", v, 16'h0051);
        host_rd(CMDB, 3'd1, v); check("abort error reg", v, 16'h0004);
        check("abort no mem_req", req_cycles - snap, 0);

        // two-sector write of 0xA5A5 at LBA 0x20
        host_wr(CMDB, 3'd2, 16'h0002);
        host_wr(CMDB, 3'd3, 16'h0020);
        log_addr.delete(); log_we.delete(); log_wdata.delete();
        host_wr(CMDB, 3'd7, 16'h0030);
        host_rd(CMDB, 3'd7, v); check("write drq status", v, 16'h0058);
        host_rd(CMDB, 3'd1, v); check("write error cleared", v, 16'h0000);
        for (int k = 0; k < 256; k++) host_wr(CMDB, 3'd0, 16'hA5A5);
        wait_status(8'h58, "write sector2 drq");
        for (int k = 0; k < 256; k++) host_wr(CMDB, 3'd0, 16'hA5A5);
        wait_status(8'h50, "write final status");
        check("write mem beats", log_addr.size(), 512);
        errs = 0;
        for (int i = 0; i < log_addr.size(); i++) begin
            e = {28'h20 + 28'(i / 256), 8'(i % 256)};
            if (log_addr[i] !== e || log_we[i] !== 1'b1 || log_wdata[i] !== 16'hA5A5) errs++;
        end
        check("write mem addr/data", errs, 0);
        host_rd(CMDB, 3'd3, v); check("write lba advanced", v, 16'h0022);

        // LBA wrap across two sectors
        host_wr(CMDB, 3'd2, 16'h0002);
        host_wr(CMDB, 3'd3, 16'h00FF);
        host_wr(CMDB, 3'd4, 16'h00FF);
        host_wr(CMDB, 3'd5, 16'h00FF);
        host_wr(CMDB, 3'd6, 16'h00EF);
        log_addr.delete(); log_we.delete(); log_wdata.delete();
        host_wr(CMDB, 3'd7, 16'h0020);
        wait_status(8'h58, "wrap sector1 drq");
        read_sector("wrap sector1 data");
        wait_status(8'h58, "wrap sector2 drq");
        read_sector("wrap sector2 data");
        host_rd(CMDB, 3'd7, v); check("wrap final status", v, 16'h0050);
        check("wrap mem beats", log_addr.size(), 512);
        check("wrap sector1 addr", log_addr.size() > 0 ? log_addr[0] : 36'hX, 36'hFFFFFFF00);
        check("wrap sector2 addr", log_addr.size() > 256 ? log_addr[256] : 36'hX, 36'h000000000);
        host_rd(CMDB, 3'd6, v); check("wrap device lba27_24", v, 16'h00E0);
        host_rd(CMDB, 3'd3, v); check("wrap lba lo", v, 16'h0001);

        // SRST in the middle of a fetch; BSY also blocks task-file writes
        host_wr(CMDB, 3'd2, 16'h0001);
        host_wr(CMDB, 3'd3, 16'h0033);
        host_wr(CMDB, 3'd7, 16'h0020);
        host_wr(CMDB, 3'd3, 16'h0077);
        repeat (5) @(posedge clk);
        #1 check("fetch active before srst", mem_req, 1'b1);
        ide_cs = CTLB; ide_da = 3'd6; ide_data_in = 16'h0004;
        @(posedge clk); #1 ide_diow = 1'b0;
        repeat (3) @(posedge clk);
        #1 ide_diow = 1'b1;
        repeat (1 + SYNC_LAT) @(posedge clk);
        #1 check("srst mem_req next cycle", mem_req, 1'b0);
        repeat (3) @(posedge clk);
        #1 ide_cs = 2'b11; ide_data_in = 16'h0000;
        host_rd(CMDB, 3'd7, v); check("srst status", v, 16'h0050);
        host_rd(CMDB, 3'd3, v); check("bsy write ignored", v, 16'h0033);
        host_rd(CMDB, 3'd0, v); check("srst data read", v, 16'h0000);

        // reset mid-fetch abandons the request
        host_wr(CMDB, 3'd7, 16'h0020);
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 check("reset mid-op mem_req", mem_req, 1'b0);
        @(posedge clk); #1 reset = 1'b0;
        snap = req_cycles;
        repeat (10) @(posedge clk);
        #1 check("no req after reset", req_cycles - snap, 0);
        host_rd(CMDB, 3'd7, v); check("reset mid-op status", v, 16'h0050);
        host_rd(CMDB, 3'd3, v); check("reset mid-op lba", v, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ide_device.md
IDE_DEVICE -- requirements
Module: ide_device

Interface
REQ-001 SHALL have port clk, input, 1, system clock; every flop is rising-edge clk.
REQ-002 SHALL have port reset, input, 1; reset is synchronous, active-high.
REQ-003 SHALL have port ide_data_in, input, 16, host write data.
REQ-004 SHALL have port ide_data_out, output, 16, registered read data to the host.
REQ-005 SHALL have ports ide_dior and ide_diow, input, 1 each, active-low read/write strobes.
REQ-006 SHALL have ports ide_cs (input, 2) and ide_da (input, 3): cs 2'b10 selects the command block, 2'b01 the control block, 2'b11 idle.
REQ-007 SHALL have ports mem_req, mem_we (output, 1), mem_addr (output, 36, {lba[27:0], word[7:0]}) and mem_wdata (output, 16).
REQ-008 SHALL have ports mem_rdata (input, 16) and mem_ack (input, 1, one-cycle pulse; rdata valid with ack).

Function
REQ-009 SHALL map command-block da 0..7 as: data, error/features, sector count, LBA low, LBA mid, LBA high, device (LBA[27:24] in bits 3:0), status/command.
REQ-010 SHALL return the status register at control-block da=6 (alt status); control-block writes at da=6 are device control.
REQ-011 SHALL assemble status as BSY bit7, DRDY6, DSC4, DRQ3, ERR0; DRDY and DSC SHALL be 1 whenever BSY=0.
REQ-012 SHALL load ide_data_out each cycle that the synced dior is low with the selected register value, zero-extended to 16 bits; the value SHALL hold otherwise.
REQ-013 SHALL capture ide_data_in into the addressed register on the synced diow rising edge; only the data register uses all 16 bits, the others use bits 7:0.
REQ-014 SHALL ignore register writes other than device control while BSY=1.
REQ-015 SHALL use FSM states IDLE, RD_FETCH, RD_XFER, WR_XFER, WR_STORE.
REQ-016 SHALL, on command 0x20 in IDLE: set BSY, clear ERR, then go to RD_FETCH.
REQ-017 SHALL, on command 0x30 in IDLE: clear ERR, set DRQ, set ptr=0, then go to WR_XFER.
REQ-018 SHALL, on any other opcode: set ERR and error-register bit2 (ABRT), and stay in IDLE.
REQ-019 SHALL, in RD_FETCH: issue 256 sequential mem reads (req held until ack) into the sector buffer; the cycle after the 256th ack: BSY=0, DRQ=1, ptr=0, state RD_XFER.
REQ-020 SHALL, in RD_XFER: drive buf[ptr] on a data-register read and increment ptr on the synced dior rising edge.
REQ-021 SHALL, after the 256th word in RD_XFER: decrement the sector count and increment the LBA; if the count is nonzero, set BSY, clear DRQ and go to RD_FETCH, else go to IDLE.
REQ-022 SHALL, in WR_XFER: write the data-register word to buf[ptr] and increment ptr on the synced diow rising edge.
REQ-023 SHALL, after the 256th word in WR_XFER: set DRQ=0, BSY=1 and go to WR_STORE, which issues 256 mem writes.
REQ-024 SHALL, at WR_STORE completion: update count/LBA as in REQ-021; if the count is nonzero, return to WR_XFER with DRQ=1 and ptr=0, else go to IDLE.
REQ-025 SHALL treat sector count 0 as 256 sectors.
REQ-026 SHALL wrap the 28-bit LBA from 0xFFFFFFF to 0.
REQ-027 SHALL, on data-register access with DRQ=0: reads return 0x0000, writes are ignored, ptr is unchanged.
REQ-028 SHALL, on a device-control write with bit2 (SRST) = 1: abort to IDLE, set status 0x50 and ptr 0, and drop mem_req the next cycle.

Reset
REQ-029 SHALL, on reset: FSM IDLE, status 0x50, all task-file registers 0, ptr 0, ide_data_out 0, mem_req 0, mem_we 0, sync flops at 1 (strobes deasserted).
REQ-030 SHALL abandon an outstanding mem request on reset mid-operation; a late ack arriving in IDLE SHALL be ignored.

Configuration
REQ-031 SHALL, with IDE_DEVICE_SYNC_EN defined: pass dior/diow through 2-flop synchronizers before edge detection (2 cycles extra latency) and register cs/da with the same delay.
REQ-032 SHALL, without IDE_DEVICE_SYNC_EN: use a single register stage on the strobes for edge detection, for same-clock hosts.

Structure
REQ-033 SHALL take FSM state enum, register offsets, status bit positions and opcodes (0x20, 0x30) from shared package ide_device_pkg.
REQ-034 SHALL implement the 256x16 sector buffer as sub-module ide_device_secbuf (1 write port, 1 synchronous read port).

Verification
REQ-035 SHALL cover: reset, then read status at cs=10 da=7 -> 0x0050.
REQ-036 SHALL cover: count=1, LBA=0x0000010, cmd 0x20, memory word k = k -> status 0x58, 256 data reads return 0..255, then status 0x50, mem_addr = 0x000001000..0x0000010FF.
REQ-037 SHALL cover: count=2, cmd 0x30, 512 writes of 0xA5A5 -> 512 mem writes to LBA sectors n and n+1, then status 0x50.
REQ-038 SHALL cover: cmd 0x91 -> status 0x51, error register 0x04, no mem_req.
REQ-039 SHALL cover: SRST write (0x04) mid RD_FETCH -> IDLE, status 0x50, mem_req low next cycle.
REQ-040 SHALL cover: LBA=0xFFFFFFF, count=2, cmd 0x20 -> second sector fetched at LBA 0.
